async_fifo_rd_stream: RTL and testbench
=======================================

// Module: async_fifo_rd_stream
// PURPOSE
//   Read-side drain engine for the dual-clock FIFO in the pixel/consumer domain.
//   - Pops words using rd_valid / fifo_empty / rd_data.
//   - Re-presents them on a valid/ready stream with a 2-entry output buffer.
//   - Sustains one word per cycle despite the FIFO's 1-cycle registered read.
//   - Feeds the VGA pixel pipeline; it is the consumer end of the FIFO.
// PARAMETERS
//   fifo_data_size  8  width of rd_data / out_data
//   cnt_size        16 width of underrun_count
// PORTS
//   clk             in   1               consumer clock (same clock as the FIFO read side)
//   reset           in   1               asynchronous, active-high
//   fifo_empty      in   1               FIFO read-side empty flag
//   rd_data         in   fifo_data_size  FIFO read data, valid the cycle after a pop
//   rd_valid        out  1               pop strobe to FIFO (advances read pointer)
//   flush           in   1               sync discard of buffered and in-flight words
//   out_valid       out  1               out_data holds a word
//   out_ready       in   1               downstream accepts; fire = out_valid & out_ready
//   out_data        out  fifo_data_size  head word of output buffer
//   underrun_count  out  cnt_size        cycles with out_ready=1 and out_valid=0; saturates
// BEHAVIOUR
//   Reset (async assert, sync release): buf_cnt=0, inflight=0, out_valid=0, out_data=0,
//     underrun_count=0. rd_valid is forced to 0 while reset=1.
//   State:
//     buf_cnt  0..2  words held in the output buffer
//     inflight 0..1  a pop was issued last cycle
//   Pop rule (combinational, same cycle):
//     rd_valid = !reset & !flush & !fifo_empty & (buf_cnt + inflight - fire < 2)
//     Must never pop when fifo_empty=1.
//   FIFO read timing: data for a pop in cycle N appears on rd_data in cycle N+1.
//   Capture: inflight=1 in cycle N+1 -> write rd_data into the buffer at the N+1 clock edge.
//   Ordering: strict FIFO. out_data is the oldest word; entry 1 shifts to entry 0 on fire.
//   Simultaneous capture and fire: the buffer count stays the same and order is preserved.
//     This applies even when buf_cnt=2 (pop allowed that cycle because fire frees a slot).
//   Latency: fifo_empty falls in cycle N -> rd_valid=1 in N -> out_valid=1 in N+2.
//   Throughput: with out_ready held at 1 and FIFO non-empty, one fire per cycle.
//   Backpressure: out_ready=0 with buf_cnt + inflight = 2 -> rd_valid=0. No word is lost.
//   out_valid = (buf_cnt != 0). out_data is stable while out_valid & !out_ready.
//   flush=1 in a cycle:
//     - Next cycle buf_cnt=0 and inflight=0; the in-flight word is dropped, not captured.
//     - rd_valid=0 in the flush cycle.
//     - A fire in the flush cycle still counts as consumed.
//     - The FIFO pointer is not rewound; discarded words are gone.
//   underrun_count: +1 per cycle with out_ready & !out_valid; holds at all-ones.
//     Cleared only by reset.
//   Reset mid-stream: buffer contents and the pending pop are discarded immediately.
//     The FIFO read side is reset by its own reset_rd.
// STRUCTURE
//   Shared package/header: stream handshake localparams (BUF_DEPTH=2) and the
//     fire/pop macros shared with the write-side stream adapter.
//   One natural sub-module: stream_skid_buf_2 (2-entry ordered buffer).
//     Ports: push, push_data, pop, head_data, count.
//   Pop/credit logic and underrun counter stay in the top module.
// TESTING
//   1 Reset, fifo_empty=1, out_ready=1 for 10 cycles -> rd_valid=0, out_valid=0,
//     underrun_count=10.
//   2 FIFO preloaded 0x01..0x08, out_ready=1 -> out_data 0x01..0x08 on 8 consecutive cycles.
//     First out_valid 2 cycles after the first rd_valid. Exactly 8 pops.
//   3 Same preload, out_ready toggles 1,0,1,0 -> no loss or duplication, order 0x01..0x08.
//     buf_cnt + inflight never exceeds 2.
//   4 out_ready=0 with a full FIFO -> exactly 2 pops, then rd_valid stays 0.
//     out_data=0x01 stable until ready.
//   5 flush asserted while buf_cnt=2, inflight=1 -> next cycle out_valid=0.
//     The next word delivered is the 4th word of the FIFO (3 discarded).
//   6 Reset pulse asynchronously mid-stream -> outputs cleared before the next clk edge.
//     Streaming resumes correctly after the FIFO is reloaded.

Source files
------------

// File: rtl/async_fifo_rd_stream_pkg.sv
// Shared stream-handshake definitions for the FIFO read/write stream adapters.
// Holds the output-buffer depth and the fire/pop-credit helpers used by both sides.
package async_fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] buf_cnt_t;

  function automatic logic stream_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

  // A pop is allowed when the words already owed to the buffer, minus the one
  // leaving this cycle, still leave a free slot for the word that will arrive.
  function automatic logic pop_credit(input buf_cnt_t buf_cnt, input logic inflight,
                                      input logic fire);
    logic [2:0] occ;
    occ = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, fire};
    return occ < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/async_fifo_rd_stream_skid_buf.sv
// Two-entry ordered buffer: entry 0 is the head, entry 1 shifts down on pop.
// A simultaneous push and pop keeps the count and preserves arrival order.
module stream_skid_buf_2
  import async_fifo_rd_stream_pkg::*;
#(
  parameter int fifo_data_size = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      push,
  input  logic [fifo_data_size-1:0] push_data,
  input  logic                      pop,
  output logic [fifo_data_size-1:0] head_data,
  output logic [1:0]                count
);

  logic [fifo_data_size-1:0] ent_q [BUF_DEPTH];
  logic [fifo_data_size-1:0] ent_d [BUF_DEPTH];
  buf_cnt_t                  count_q, count_d;
  buf_cnt_t                  wr_idx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    wr_idx  = count_q - {1'b0, pop};
    if (pop) ent_d[0] = ent_q[1];
    if (push) begin
      if (wr_idx == 2'd0) ent_d[0] = push_data;
      else                ent_d[1] = push_data;
    end
    if (clear) count_d = '0;
  end

  // NOTE: storage is reset as well as the count, because the head must read 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign head_data = ent_q[0];
  assign count     = count_q;

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Consumer-side drain engine: pops the dual-clock FIFO (1-cycle registered read)
// and re-presents words on a valid/ready stream at one word per cycle.
module async_fifo_rd_stream
  import async_fifo_rd_stream_pkg::*;
#(
  parameter int fifo_data_size = 8,
  parameter int cnt_size       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fifo_empty,
  input  logic [fifo_data_size-1:0] rd_data,
  output logic                      rd_valid,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [fifo_data_size-1:0] out_data,
  output logic [cnt_size-1:0]       underrun_count
);

  buf_cnt_t            buf_cnt;
  logic                fire;
  logic                capture;
  logic                inflight_q, inflight_d;
  logic [cnt_size-1:0] underrun_q, underrun_d;

  assign out_valid = (buf_cnt != 2'd0);
  assign fire      = stream_fire(out_valid, out_ready);
  assign rd_valid  = !reset & !flush & !fifo_empty & pop_credit(buf_cnt, inflight_q, fire);
  // The word popped last cycle is on rd_data now; a flush drops it instead.
  assign capture   = inflight_q & !flush;

  stream_skid_buf_2 #(
    .fifo_data_size(fifo_data_size)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (capture),
    .push_data(rd_data),
    .pop      (fire),
    .head_data(out_data),
    .count    (buf_cnt)
  );

  always_comb begin
    inflight_d = rd_valid;
    underrun_d = underrun_q;
    if (out_ready && !out_valid && !(&underrun_q)) underrun_d = underrun_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      underrun_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      underrun_q <= underrun_d;
    end
  end

  assign underrun_count = underrun_q;

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: behavioural FIFO with 1-cycle registered read,
// scoreboard of loaded words compared against every fired output word.
module tb_async_fifo_rd_stream;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset, fifo_empty, rd_valid, flush, out_valid, out_ready, fifo_clr;
  logic [W-1:0] rd_data, out_data;
  logic [C-1:0] underrun_count;

  logic [W-1:0] mem [256];
  int           wr_ptr = 0;
  int           rd_ptr = 0;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] exp_q [$];
  int           pops, fires, max_out, empty_pop_err;
  logic         obs_rdv, obs_valid, obs_fire;
  logic [W-1:0] obs_data, e;

  async_fifo_rd_stream #(
    .fifo_data_size(W),
    .cnt_size      (C)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty    (fifo_empty),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  // FIFO read side: data for a pop in cycle N is on rd_data in cycle N+1.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (rd_valid) begin
      rd_data <= mem[rd_ptr % 256];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  task automatic load(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 256] = base + W'(i);
      exp_q.push_back(base + W'(i));
      wr_ptr++;
    end
  endtask

  function automatic logic [W-1:0] next_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Sample what the next rising edge will see, then advance one cycle.
  task automatic tick();
    #1;
    obs_rdv   = rd_valid;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_fire  = out_valid & out_ready;
    if (rd_valid && fifo_empty) empty_pop_err++;
    if (rd_valid) pops++;
    if (obs_fire) fires++;
    if (pops - fires > max_out) max_out = pops - fires;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    reset = 1'b1; fifo_clr = 1'b1; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    n_checks++; if (rd_valid !== 1'b0 || out_valid !== 1'b0) $display("FAIL rst_outputs rd_valid=%b out_valid=%b need 0/0", rd_valid, out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL rst_data got %h need 00", out_data); else n_pass++;
    reset = 1'b0; fifo_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_rdv !== 1'b0 || obs_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL idle_quiet got %0d active cycles need 0", bad); else n_pass++;
    #1;
    n_checks++; if (underrun_count !== 4'd10) $display("FAIL underrun_10 got %0d need 10", underrun_count); else n_pass++;
    for (int i = 0; i < 8; i++) tick();
    #1;
    n_checks++; if (underrun_count !== 4'hF) $display("FAIL underrun_sat got %0d need 15", underrun_count); else n_pass++;
  endtask

  task automatic test_stream();
    int first_rd, first_ov, first_fire, last_fire;
    first_rd = -1; first_ov = -1; first_fire = -1; last_fire = -1;
    pops = 0; fires = 0; empty_pop_err = 0;
    out_ready = 1'b1;
    load(8, 8'h01);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (obs_rdv && first_rd < 0) first_rd = i;
      if (obs_valid && first_ov < 0) first_ov = i;
      if (obs_fire) begin
        if (first_fire < 0) first_fire = i;
        last_fire = i;
        e = next_exp();
        n_checks++; if (obs_data !== e) $display("FAIL stream_data got %h need %h", obs_data, e); else n_pass++;
      end
    end
    n_checks++; if (first_ov - first_rd != 2) $display("FAIL stream_latency got %0d need 2", first_ov - first_rd); else n_pass++;
    n_checks++; if (last_fire - first_fire != 7 || fires != 8) $display("FAIL stream_rate span %0d fires %0d need 7/8", last_fire - first_fire, fires); else n_pass++;
    n_checks++; if (pops != 8 || empty_pop_err != 0) $display("FAIL stream_pops got %0d (empty pops %0d) need 8 (0)", pops, empty_pop_err); else n_pass++;
  endtask

  task automatic test_toggle_ready();
    pops = 0; fires = 0; max_out = 0;
    load(8, 8'h01);
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 2 == 0);
      tick();
      if (obs_fire) begin
        e = next_exp();
        n_checks++; if (obs_data !== e) $display("FAIL toggle_data got %h need %h", obs_data, e); else n_pass++;
      end
    end
    n_checks++; if (fires != 8 || pops != 8 || exp_q.size() != 0) $display("FAIL toggle_count fires %0d pops %0d left %0d need 8/8/0", fires, pops, exp_q.size()); else n_pass++;
    n_checks++; if (max_out > 2) $display("FAIL toggle_occupancy got %0d need <=2", max_out); else n_pass++;
  endtask

  task automatic test_stall();
    int unstable;
    unstable = 0; pops = 0; fires = 0;
    out_ready = 1'b0;
    load(8, 8'h41);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_valid && obs_data !== 8'h41) unstable++;
    end
    n_checks++; if (pops != 2 || obs_rdv !== 1'b0) $display("FAIL stall_pops got %0d rd_valid=%b need 2/0", pops, obs_rdv); else n_pass++;
    n_checks++; if (unstable != 0 || obs_valid !== 1'b1 || obs_data !== 8'h41) $display("FAIL stall_head got %h valid=%b need 41/1", obs_data, obs_valid); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (obs_fire) begin
        e = next_exp();
        n_checks++; if (obs_data !== e) $display("FAIL stall_data got %h need %h", obs_data, e); else n_pass++;
      end
    end
    n_checks++; if (fires != 8 || pops != 8) $display("FAIL stall_count fires %0d pops %0d need 8/8", fires, pops); else n_pass++;
  endtask

  task automatic test_flush();
    // Buffer full and idle: both held words are discarded.
    out_ready = 1'b0;
    load(6, 8'h51);
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    tick();
    n_checks++; if (obs_rdv !== 1'b0) $display("FAIL flush_full_pop got %b need 0", obs_rdv); else n_pass++;
    flush = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_full_valid got %b need 0", out_valid); else n_pass++;
    void'(next_exp()); void'(next_exp());
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_fire) begin
        e = next_exp();
        n_checks++; if (obs_data !== e) $display("FAIL flush_full_data got %h need %h", obs_data, e); else n_pass++;
      end
    end
    // Streaming: the word firing in the flush cycle is consumed, the in-flight one is dropped.
    fires = 0;
    load(6, 8'h61);
    for (int i = 0; i < 10 && fires < 2; i++) begin
      tick();
      if (obs_fire) begin
        e = next_exp();
        n_checks++; if (obs_data !== e) $display("FAIL flush_stream_data got %h need %h", obs_data, e); else n_pass++;
      end
    end
    flush = 1'b1;
    tick();
    e = next_exp();
    n_checks++; if (obs_fire !== 1'b1 || obs_data !== e || obs_rdv !== 1'b0) $display("FAIL flush_stream_fire got %h fire=%b rd_valid=%b need %h/1/0", obs_data, obs_fire, obs_rdv, e); else n_pass++;
    flush = 1'b0;
    void'(next_exp());
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_fire) begin
        e = next_exp();
        n_checks++; if (obs_data !== e) $display("FAIL flush_resume_data got %h need %h", obs_data, e); else n_pass++;
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL flush_left got %0d need 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    load(6, 8'h71);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs_fire) begin
        e = next_exp();
        n_checks++; if (obs_data !== e) $display("FAIL midrst_pre_data got %h need %h", obs_data, e); else n_pass++;
      end
    end
    #2;
    reset = 1'b1; fifo_clr = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || rd_valid !== 1'b0) $display("FAIL midrst_async out_valid=%b rd_valid=%b need 0/0", out_valid, rd_valid); else n_pass++;
    n_checks++; if (out_data !== '0 || underrun_count !== '0) $display("FAIL midrst_clear data %h underrun %0d need 00/0", out_data, underrun_count); else n_pass++;
    tick();
    reset = 1'b0; fifo_clr = 1'b0;
    exp_q.delete();
    fires = 0;
    load(4, 8'h81);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_fire) begin
        e = next_exp();
        n_checks++; if (obs_data !== e) $display("FAIL midrst_post_data got %h need %h", obs_data, e); else n_pass++;
      end
    end
    n_checks++; if (fires != 4) $display("FAIL midrst_count got %0d need 4", fires); else n_pass++;
  endtask

  initial begin
    pops = 0; fires = 0; max_out = 0; empty_pop_err = 0;
    test_reset();
    test_stream();
    test_toggle_ready();
    test_stall();
    test_flush();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
